// File: rtl/reg_bus_hub.sv
// Register-bus hub: one requester broadcast to N_SLAVES register slaves, with transaction FSM,
// timeout, multi-ack collision detection, sticky error flags and a saturating error counter.
module reg_bus_hub #(
  parameter int N_SLAVES = 3,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 4,
  parameter int TIMEOUT  = 15,
  parameter int CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       m_valid,
  input  logic [ADDR_W-1:0]          m_address,
  input  logic [DATA_W-1:0]          m_data,
  output logic                       m_ack,
  output logic [DATA_W-1:0]          m_rdata,
  output logic                       m_rdata_valid,
  output logic                       m_err,
  output logic                       s_valid,
  output logic [ADDR_W-1:0]          s_address,
  output logic [DATA_W-1:0]          s_data,
  input  logic [N_SLAVES-1:0]        s_ack,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [N_SLAVES-1:0]        s_rdata_valid,
  output logic [N_SLAVES-1:0]        resp_map,
  output logic                       sticky_to,
  output logic                       sticky_coll,
  output logic [CNT_W-1:0]           err_count
);

  localparam int TMR_W = $clog2(TIMEOUT + 2);
  localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [TMR_W-1:0]    TMR_ONE  = TMR_W'(1);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [N_SLAVES-1:0] N_ONE    = N_SLAVES'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // OR of every slave data slice whose valid bit is set.
  function automatic logic [DATA_W-1:0] or_valid_slices(
    input logic [N_SLAVES*DATA_W-1:0] rdata,
    input logic [N_SLAVES-1:0]        vld
  );
    logic [DATA_W-1:0] acc;
    acc = {DATA_W{1'b0}};
    for (int i = 0; i < N_SLAVES; i++) begin
      acc = acc | (rdata[i*DATA_W +: DATA_W] & {DATA_W{vld[i]}});
    end
    return acc;
  endfunction

  // True when more than one bit of the vector is set.
  function automatic logic multi_hot(input logic [N_SLAVES-1:0] v);
    return (v & (v - N_ONE)) != {N_SLAVES{1'b0}};
  endfunction

  state_t              state_r, state_s;
  logic [TMR_W-1:0]    timer_r, timer_s;
  logic                s_valid_r, s_valid_s;
  logic [ADDR_W-1:0]   s_address_r, s_address_s;
  logic [DATA_W-1:0]   s_data_r, s_data_s;
  logic [DATA_W-1:0]   data_r, data_s;
  logic                rv_r, rv_s;
  logic [N_SLAVES-1:0] resp_map_r, resp_map_s;
  logic                sticky_to_r, sticky_to_s;
  logic                sticky_coll_r, sticky_coll_s;
  logic [CNT_W-1:0]    err_count_r, err_count_s;
  logic                m_ack_r, m_ack_s;
  logic                m_err_r, m_err_s;
  logic [DATA_W-1:0]   m_rdata_r, m_rdata_s;
  logic                m_rdata_valid_r, m_rdata_valid_s;
  logic                finish_s, fin_err_s, timeout_hit_s;

  assign timeout_hit_s = (TIMEOUT != 0) && (timer_r == TMR_LAST);

  // Next-state and next-output logic for the IDLE -> REQ -> DONE transaction FSM.
  always_comb begin
    state_s         = state_r;
    timer_s         = timer_r;
    s_valid_s       = s_valid_r;
    s_address_s     = s_address_r;
    s_data_s        = s_data_r;
    data_s          = data_r;
    rv_s            = rv_r;
    resp_map_s      = resp_map_r;
    sticky_to_s     = sticky_to_r;
    sticky_coll_s   = sticky_coll_r;
    err_count_s     = err_count_r;
    m_ack_s         = 1'b0;
    m_err_s         = 1'b0;
    m_rdata_s       = {DATA_W{1'b0}};
    m_rdata_valid_s = 1'b0;
    finish_s        = 1'b0;
    fin_err_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (m_valid) begin
          state_s     = ST_REQ;
          s_valid_s   = 1'b1;
          s_address_s = m_address;
          s_data_s    = m_data;
          timer_s     = {TMR_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        timer_s = timer_r + TMR_ONE;
        if (|s_rdata_valid) begin
          data_s = or_valid_slices(s_rdata, s_rdata_valid);
          rv_s   = 1'b1;
        end else begin
          data_s = data_r;
          rv_s   = rv_r;
        end
        // An ack in the final timer cycle still completes normally.
        if (|s_ack) begin
          finish_s      = 1'b1;
          fin_err_s     = multi_hot(s_ack);
          resp_map_s    = s_ack;
          sticky_coll_s = sticky_coll_r | fin_err_s;
        end else if (timeout_hit_s) begin
          finish_s    = 1'b1;
          fin_err_s   = 1'b1;
          resp_map_s  = {N_SLAVES{1'b0}};
          sticky_to_s = 1'b1;
        end else begin
          state_s = ST_REQ;
        end
        if (finish_s) begin
          state_s         = ST_DONE;
          s_valid_s       = 1'b0;
          m_ack_s         = 1'b1;
          m_err_s         = fin_err_s;
          m_rdata_valid_s = rv_s & ~fin_err_s;
          m_rdata_s       = m_rdata_valid_s ? data_s : {DATA_W{1'b0}};
          if (fin_err_s && (err_count_r != CNT_MAX)) begin
            err_count_s = err_count_r + CNT_ONE;
          end else begin
            err_count_s = err_count_r;
          end
        end else begin
          s_valid_s = 1'b1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        rv_s    = 1'b0;
        timer_s = {TMR_W{1'b0}};
      end
      default: begin
        state_s   = ST_IDLE;
        s_valid_s = 1'b0;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      timer_r         <= {TMR_W{1'b0}};
      s_valid_r       <= 1'b0;
      s_address_r     <= {ADDR_W{1'b0}};
      s_data_r        <= {DATA_W{1'b0}};
      data_r          <= {DATA_W{1'b0}};
      rv_r            <= 1'b0;
      resp_map_r      <= {N_SLAVES{1'b0}};
      sticky_to_r     <= 1'b0;
      sticky_coll_r   <= 1'b0;
      err_count_r     <= {CNT_W{1'b0}};
      m_ack_r         <= 1'b0;
      m_err_r         <= 1'b0;
      m_rdata_r       <= {DATA_W{1'b0}};
      m_rdata_valid_r <= 1'b0;
    end else begin
      state_r         <= state_s;
      timer_r         <= timer_s;
      s_valid_r       <= s_valid_s;
      s_address_r     <= s_address_s;
      s_data_r        <= s_data_s;
      data_r          <= data_s;
      rv_r            <= rv_s;
      resp_map_r      <= resp_map_s;
      sticky_to_r     <= sticky_to_s;
      sticky_coll_r   <= sticky_coll_s;
      err_count_r     <= err_count_s;
      m_ack_r         <= m_ack_s;
      m_err_r         <= m_err_s;
      m_rdata_r       <= m_rdata_s;
      m_rdata_valid_r <= m_rdata_valid_s;
    end
  end

  assign m_ack         = m_ack_r;
  assign m_err         = m_err_r;
  assign m_rdata       = m_rdata_r;
  assign m_rdata_valid = m_rdata_valid_r;
  assign s_valid       = s_valid_r;
  assign s_address     = s_address_r;
  assign s_data        = s_data_r;
  assign resp_map      = resp_map_r;
  assign sticky_to     = sticky_to_r;
  assign sticky_coll   = sticky_coll_r;
  assign err_count     = err_count_r;

endmodule

// File: tb/tb_reg_bus_hub.sv
// Self-checking bench for reg_bus_hub: directed table, random transactions against a
// transaction-level model, reset-in-REQ and error-counter saturation sequences.
module tb_reg_bus_hub;

  localparam int N  = 3;
  localparam int AW = 4;
  localparam int DW = 4;
  localparam int TO = 15;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            m_valid = 1'b0;
  logic [AW-1:0]   m_address = '0;
  logic [DW-1:0]   m_data = '0;
  logic            m_ack;
  logic [DW-1:0]   m_rdata;
  logic            m_rdata_valid;
  logic            m_err;
  logic            s_valid;
  logic [AW-1:0]   s_address;
  logic [DW-1:0]   s_data;
  logic [N-1:0]    s_ack = '0;
  logic [N*DW-1:0] s_rdata = '0;
  logic [N-1:0]    s_rdata_valid = '0;
  logic [N-1:0]    resp_map;
  logic            sticky_to;
  logic            sticky_coll;
  logic [CW-1:0]   err_count;

  reg_bus_hub #(.N_SLAVES(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_address(m_address), .m_data(m_data),
    .m_ack(m_ack), .m_rdata(m_rdata), .m_rdata_valid(m_rdata_valid), .m_err(m_err),
    .s_valid(s_valid), .s_address(s_address), .s_data(s_data), .s_ack(s_ack),
    .s_rdata(s_rdata), .s_rdata_valid(s_rdata_valid), .resp_map(resp_map),
    .sticky_to(sticky_to), .sticky_coll(sticky_coll), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Expected sticky state, maintained across transactions.
  bit            exp_to = 1'b0;
  bit            exp_coll = 1'b0;
  logic [CW-1:0] exp_cnt = '0;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    int              ack_dly;   // REQ cycle index (0 = first s_valid cycle) of the ack
    logic [N-1:0]    ack_vec;   // 0 = nobody acks
    int              rv_dly;    // REQ cycle index of rdata_valid, -1 = none
    logic [N-1:0]    rv_vec;
    logic [N*DW-1:0] rdata;
    int              exp_cyc;   // cycles from first s_valid cycle to m_ack
    bit              exp_err;
    bit              exp_rv;
    logic [DW-1:0]   exp_rdata;
    logic [N-1:0]    exp_resp;
  } txn_t;

  txn_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic [AW-1:0] a, input logic [DW-1:0] d, input int adly,
                              input logic [N-1:0] av, input int rdly, input logic [N-1:0] rvv,
                              input logic [N*DW-1:0] rd, input int ecyc, input bit eerr,
                              input bit erv, input logic [DW-1:0] erd, input logic [N-1:0] eresp);
    txn_t t;
    t.addr = a; t.data = d; t.ack_dly = adly; t.ack_vec = av; t.rv_dly = rdly;
    t.rv_vec = rvv; t.rdata = rd; t.exp_cyc = ecyc; t.exp_err = eerr; t.exp_rv = erv;
    t.exp_rdata = erd; t.exp_resp = eresp;
    return t;
  endfunction

  // Transaction-level outcome from the bus rules: who wins, when, and what data returns.
  function automatic txn_t model(input txn_t t);
    bit to, coll, rv;
    int done;
    to   = (t.ack_vec == '0) || (t.ack_dly > TO - 1);
    done = to ? TO - 1 : t.ack_dly;
    coll = !to && ($countones(t.ack_vec) > 1);
    rv   = (t.rv_dly >= 0) && (t.rv_dly <= done) && (t.rv_vec != '0);
    t.exp_cyc   = done + 1;
    t.exp_err   = to || coll;
    t.exp_rv    = rv && !t.exp_err;
    t.exp_rdata = '0;
    if (t.exp_rv) begin
      for (int i = 0; i < N; i++) begin
        if (t.rv_vec[i]) t.exp_rdata = t.exp_rdata | t.rdata[i*DW +: DW];
      end
    end
    t.exp_resp = to ? '0 : t.ack_vec;
    return t;
  endfunction

  // Runs one transaction starting at a negedge in IDLE; returns at the negedge after DONE.
  task automatic run_txn(input txn_t t, input bit hold);
    bit got, sv_drop;
    int cyc;
    m_valid = 1'b1; m_address = t.addr; m_data = t.data;
    s_ack = N'($urandom); s_rdata_valid = N'($urandom); s_rdata = (N*DW)'($urandom);
    @(negedge clk);
    chk("s_valid_rise", 32'(s_valid), 32'd1);
    chk("s_address", 32'(s_address), 32'(t.addr));
    chk("s_data", 32'(s_data), 32'(t.data));
    cyc = 0; got = 1'b0; sv_drop = 1'b0;
    while (!got && cyc < 40) begin
      s_ack         = (cyc == t.ack_dly) ? t.ack_vec : '0;
      s_rdata_valid = (cyc == t.rv_dly) ? t.rv_vec : '0;
      s_rdata       = t.rdata;
      @(negedge clk);
      cyc++;
      if (m_ack) got = 1'b1;
      else if (s_valid !== 1'b1) sv_drop = 1'b1;
    end
    chk("ack_seen", 32'(got), 32'd1);
    chk("ack_latency", 32'(cyc), 32'(t.exp_cyc));
    chk("s_valid_held", 32'(sv_drop), 32'd0);
    chk("s_valid_done", 32'(s_valid), 32'd0);
    chk("m_err", 32'(m_err), 32'(t.exp_err));
    chk("m_rdata_valid", 32'(m_rdata_valid), 32'(t.exp_rv));
    chk("m_rdata", 32'(m_rdata), 32'(t.exp_rdata));
    chk("resp_map", 32'(resp_map), 32'(t.exp_resp));
    if (t.exp_err && t.exp_resp == '0) exp_to = 1'b1;
    if (t.exp_err && t.exp_resp != '0) exp_coll = 1'b1;
    if (t.exp_err && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    // DONE cycle: m_valid ignored, slave responses ignored.
    m_valid = hold;
    if (hold) begin
      m_address = AW'($urandom); m_data = DW'($urandom);
    end
    s_ack = N'($urandom); s_rdata_valid = N'($urandom); s_rdata = (N*DW)'($urandom);
    @(negedge clk);
    chk("ack_pulse", 32'(m_ack), 32'd0);
    chk("idle_s_valid", 32'(s_valid), 32'd0);
    chk("s_address_hold", 32'(s_address), 32'(t.addr));
    chk("s_data_hold", 32'(s_data), 32'(t.data));
    chk("resp_map_hold", 32'(resp_map), 32'(t.exp_resp));
    chk("sticky_to", 32'(sticky_to), 32'(exp_to));
    chk("sticky_coll", 32'(sticky_coll), 32'(exp_coll));
    chk("err_count", 32'(err_count), 32'(exp_cnt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    bit   spurious;
    int   r;

    //          addr   data  adly ack     rdly rv      rdata    cyc err rv rdata resp
    tbl[0] = mk(4'h2, 4'hA, 2,  3'b010, -1, 3'b000, 12'h000, 3,  0, 0, 4'h0, 3'b010);
    tbl[1] = mk(4'h5, 4'h0, 1,  3'b100, 1,  3'b100, 12'h500, 2,  0, 1, 4'h5, 3'b100);
    tbl[2] = mk(4'h9, 4'h3, 0,  3'b000, -1, 3'b000, 12'h000, 15, 1, 0, 4'h0, 3'b000);
    tbl[3] = mk(4'hC, 4'h4, 0,  3'b101, 0,  3'b001, 12'h007, 1,  1, 0, 4'h0, 3'b101);
    tbl[4] = mk(4'h1, 4'h8, 3,  3'b001, 0,  3'b011, 12'h0C3, 4,  0, 1, 4'hF, 3'b001);
    tbl[5] = mk(4'hE, 4'h2, 14, 3'b100, -1, 3'b000, 12'h000, 15, 0, 0, 4'h0, 3'b100);
    tbl[6] = mk(4'h6, 4'h5, 0,  3'b000, 3,  3'b010, 12'h090, 15, 1, 0, 4'h0, 3'b000);
    tbl[7] = mk(4'h3, 4'hF, 0,  3'b010, 0,  3'b010, 12'h090, 1,  0, 1, 4'h9, 3'b010);

    repeat (3) @(negedge clk);
    chk("rst_m_ack", 32'(m_ack), 32'd0);
    chk("rst_m_err", 32'(m_err), 32'd0);
    chk("rst_m_rdata", 32'(m_rdata), 32'd0);
    chk("rst_m_rdata_valid", 32'(m_rdata_valid), 32'd0);
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_s_address", 32'(s_address), 32'd0);
    chk("rst_s_data", 32'(s_data), 32'd0);
    chk("rst_resp_map", 32'(resp_map), 32'd0);
    chk("rst_sticky_to", 32'(sticky_to), 32'd0);
    chk("rst_sticky_coll", 32'(sticky_coll), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_txn(tbl[i], i == 1);

    for (int n = 0; n < 40; n++) begin
      t.addr    = AW'($urandom);
      t.data    = DW'($urandom);
      r         = int'($urandom_range(0, 9));
      t.ack_vec = (r == 0) ? N'(0) : (r == 1) ? N'($urandom) : N'(1 << $urandom_range(0, N - 1));
      t.ack_dly = int'($urandom_range(0, 17));
      t.rv_dly  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 16));
      t.rv_vec  = N'($urandom);
      t.rdata   = (N*DW)'($urandom);
      t = model(t);
      run_txn(t, $urandom_range(0, 3) == 0);
    end

    // Reset while in REQ: transaction aborted without m_ack, status cleared.
    m_valid = 1'b1; m_address = 4'h7; m_data = 4'h1; s_ack = '0; s_rdata_valid = '0;
    @(negedge clk);
    chk("pre_rst_s_valid", 32'(s_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_s_valid", 32'(s_valid), 32'd0);
    chk("midrst_m_ack", 32'(m_ack), 32'd0);
    chk("midrst_sticky_to", 32'(sticky_to), 32'd0);
    chk("midrst_sticky_coll", 32'(sticky_coll), 32'd0);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    chk("midrst_resp_map", 32'(resp_map), 32'd0);
    chk("midrst_s_address", 32'(s_address), 32'd0);
    rst = 1'b0; m_valid = 1'b0;
    exp_to = 1'b0; exp_coll = 1'b0; exp_cnt = '0;
    spurious = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (m_ack !== 1'b0 || s_valid !== 1'b0) spurious = 1'b1;
    end
    chk("midrst_no_ack", 32'(spurious), 32'd0);
    run_txn(tbl[0], 1'b0);

    // Forced timeouts until the error counter saturates.
    for (int k = 0; k < 256; k++) run_txn(tbl[2], 1'b0);
    chk("err_count_sat", 32'(err_count), 32'hFF);
    m_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
